// File: rtl/aes128_ctrl_pkg.sv
// Shared definitions for the AES-128 round controller: FSM state encoding,
// round-constant seed and reduction polynomial, and the GF(2^8) doubling
// helper used to step RCON from one round to the next.
package aes128_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_rcon_gen.sv
// Round-constant register. load_init reseeds it to 01 (new block or abort),
// advance steps it by xtime once per completed round. Shared with the
// key-expansion block so both sides see an identical RCON sequence.
module aes128_rcon_gen
  import aes128_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_init,
  input  logic       advance,
  output logic [7:0] rcon
);

  // Reseed has priority over advance so a restart never sees a stale value.
  always_ff @(posedge clk) begin
    if (rst || load_init) begin
      rcon <= RCON_INIT;
    end else if (advance) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Sequencing controller for the AES-128 encrypt datapath. Walks the
// datapath through the initial AddRoundKey, NUM_ROUNDS-1 middle rounds and
// the final round, each round lasting ROUND_CYCLES clocks, then holds the
// result behind a valid/ready handshake.
// Optional build macro AES128_ROUND_CTRL_ABORT_EN adds an ABORT input that
// returns the controller to IDLE from any busy state.
module aes128_round_ctrl
  import aes128_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START_VALID,
  output logic       START_READY,
  output logic [3:0] ROUND_NUM,
  output logic [7:0] RCON,
  output logic       SEL_INIT,
  output logic       SEL_FINAL,
  output logic       STATE_EN,
  output logic       KEY_EN,
  output logic       BUSY,
  output logic       DONE_VALID,
  input  logic       DONE_READY
`ifdef AES128_ROUND_CTRL_ABORT_EN
  ,
  input  logic       ABORT
`endif
);

  localparam logic [1:0] SUB_LAST   = 2'(ROUND_CYCLES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  // With single-cycle rounds the very first sub-cycle is also the last one.
  localparam logic       FIRST_EN   = (ROUND_CYCLES == 1);

  state_t     state;
  logic [1:0] sub_cnt;
  logic [3:0] round_num;
  logic       start_ready;
  logic       sel_init;
  logic       sel_final;
  logic       state_en;
  logic       key_en;
  logic       busy;
  logic       done_valid;
  logic       abort_hit;
  logic       sub_last;
  logic       rcon_load;
  logic       rcon_advance;
  logic [7:0] rcon;

`ifdef AES128_ROUND_CTRL_ABORT_EN
  assign abort_hit = ABORT && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign sub_last     = (sub_cnt == SUB_LAST);
  assign rcon_load    = ((state == IDLE) && START_VALID) || abort_hit;
  assign rcon_advance = (state == ROUND) && sub_last;

  aes128_rcon_gen u_rcon (
    .clk       (CLK),
    .rst       (RST),
    .load_init (rcon_load),
    .advance   (rcon_advance),
    .rcon      (rcon)
  );

  // Main FSM; every output is computed for the next state and registered.
  always_ff @(posedge CLK) begin
    if (RST || abort_hit) begin
      state       <= IDLE;
      sub_cnt     <= '0;
      round_num   <= '0;
      start_ready <= 1'b1;
      sel_init    <= 1'b0;
      sel_final   <= 1'b0;
      state_en    <= 1'b0;
      key_en      <= 1'b0;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START_VALID) begin
            state       <= INIT;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            sel_init    <= 1'b1;
            state_en    <= 1'b1;
            key_en      <= 1'b1;
            round_num   <= '0;
            sub_cnt     <= '0;
          end
        end
        INIT: begin
          state     <= ROUND;
          sel_init  <= 1'b0;
          round_num <= 4'd1;
          sub_cnt   <= '0;
          state_en  <= FIRST_EN;
          key_en    <= FIRST_EN;
        end
        ROUND: begin
          if (sub_last) begin
            sub_cnt   <= '0;
            round_num <= round_num + 4'd1;
            state_en  <= FIRST_EN;
            key_en    <= FIRST_EN;
            if (round_num + 4'd1 == LAST_ROUND) begin
              state     <= FINAL;
              sel_final <= 1'b1;
            end
          end else begin
            sub_cnt  <= sub_cnt + 2'd1;
            state_en <= (sub_cnt + 2'd1 == SUB_LAST);
            key_en   <= (sub_cnt + 2'd1 == SUB_LAST);
          end
        end
        FINAL: begin
          if (sub_last) begin
            state      <= DONE;
            sub_cnt    <= '0;
            sel_final  <= 1'b0;
            state_en   <= 1'b0;
            key_en     <= 1'b0;
            done_valid <= 1'b1;
          end else begin
            sub_cnt  <= sub_cnt + 2'd1;
            state_en <= (sub_cnt + 2'd1 == SUB_LAST);
            key_en   <= (sub_cnt + 2'd1 == SUB_LAST);
          end
        end
        DONE: begin
          if (DONE_READY) begin
            state       <= IDLE;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            round_num   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign START_READY = start_ready;
  assign ROUND_NUM   = round_num;
  assign RCON        = rcon;
  assign SEL_INIT    = sel_init;
  assign SEL_FINAL   = sel_final;
  assign STATE_EN    = state_en;
  assign KEY_EN      = key_en;
  assign BUSY        = busy;
  assign DONE_VALID  = done_valid;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: a default instance and a
// three-cycle-per-round instance, driven with directed vectors.
// Build with AES128_ROUND_CTRL_ABORT_EN to include the abort sequence.
module tb_aes128_round_ctrl;

  typedef struct {
    logic [6:0] ctrl;     // {sel_init, sel_final, state_en, key_en, busy, done_valid, start_ready}
    logic       chk_num;
    logic [3:0] round_num;
    logic [7:0] rcon;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start_valid, done_ready;
  logic start_valid3, done_ready3;
`ifdef AES128_ROUND_CTRL_ABORT_EN
  logic abort;
`endif

  logic       start_ready, sel_init, sel_final, state_en, key_en, busy, done_valid;
  logic [3:0] round_num;
  logic [7:0] rcon;
  logic       start_ready3, sel_init3, sel_final3, state_en3, key_en3, busy3, done_valid3;
  logic [3:0] round_num3;
  logic [7:0] rcon3;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t       tbl[13];
  logic [7:0] rcon_seq[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  always #5 clk = ~clk;

  aes128_round_ctrl dut (
    .CLK         (clk),
    .RST         (rst),
    .START_VALID (start_valid),
    .START_READY (start_ready),
    .ROUND_NUM   (round_num),
    .RCON        (rcon),
    .SEL_INIT    (sel_init),
    .SEL_FINAL   (sel_final),
    .STATE_EN    (state_en),
    .KEY_EN      (key_en),
    .BUSY        (busy),
    .DONE_VALID  (done_valid),
    .DONE_READY  (done_ready)
`ifdef AES128_ROUND_CTRL_ABORT_EN
    ,
    .ABORT       (abort)
`endif
  );

  aes128_round_ctrl #(.ROUND_CYCLES(3)) dut3 (
    .CLK         (clk),
    .RST         (rst),
    .START_VALID (start_valid3),
    .START_READY (start_ready3),
    .ROUND_NUM   (round_num3),
    .RCON        (rcon3),
    .SEL_INIT    (sel_init3),
    .SEL_FINAL   (sel_final3),
    .STATE_EN    (state_en3),
    .KEY_EN      (key_en3),
    .BUSY        (busy3),
    .DONE_VALID  (done_valid3),
    .DONE_READY  (done_ready3)
`ifdef AES128_ROUND_CTRL_ABORT_EN
    ,
    .ABORT       (1'b0)
`endif
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  function automatic logic [6:0] ctrl_bits();
    return {sel_init, sel_final, state_en, key_en, busy, done_valid, start_ready};
  endfunction

  // Drive the start handshake for one cycle on the default instance.
  task automatic apply_stimulus(input logic sv, input logic dr);
    start_valid = sv;
    done_ready  = dr;
    tick();
  endtask

  // Pulse a start and count cycles until DONE_VALID; -1 when the bound expires.
  task automatic start_and_time(input int limit, output int lat);
    apply_stimulus(1'b1, done_ready);
    start_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < limit) begin
      tick();
      lat++;
    end
    if (!done_valid) lat = -1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || done_valid) && k < 60) begin
      tick();
      k++;
    end
    check_output(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int se_count;
    int lat;
    int first_init;
    int second_init;
    int dv_seen;

    // Expected trace for cycles 1..13 after a start with DONE_READY high.
    for (int i = 0; i < 13; i++) begin
      tbl[i].chk_num   = 1'b0;
      tbl[i].round_num = 4'd0;
      tbl[i].rcon      = 8'h00;
      if (i == 0) begin
        tbl[i].ctrl = 7'b1011100; tbl[i].chk_num = 1'b1;
        tbl[i].round_num = 4'd0;  tbl[i].rcon = 8'h01;
      end else if (i <= 9) begin
        tbl[i].ctrl = (i == 10 - 0 - 0 && 0) ? 7'b0 : 7'b0011100;
        tbl[i].chk_num = 1'b1;
        tbl[i].round_num = 4'(i);
        tbl[i].rcon = rcon_seq[i - 1];
      end else if (i == 10) begin
        tbl[i].ctrl = 7'b0111100; tbl[i].chk_num = 1'b1;
        tbl[i].round_num = 4'd10; tbl[i].rcon = 8'h36;
      end else if (i == 11) begin
        tbl[i].ctrl = 7'b0000110;
      end else begin
        tbl[i].ctrl = 7'b0000001;
      end
    end

    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b1;
    start_valid3 = 1'b0; done_ready3 = 1'b1;
`ifdef AES128_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    check_output("reset_ctrl", ctrl_bits(), 7'b0000001);
    check_output("reset_round_num", round_num, 0);
    check_output("reset_rcon", rcon, 8'h01);
    check_output("reset3_ctrl",
                 {sel_init3, sel_final3, state_en3, key_en3, busy3, done_valid3, start_ready3},
                 7'b0000001);

    // Default sequence against the table.
    apply_stimulus(1'b1, 1'b1);
    start_valid = 1'b0;
    se_count = 0;
    for (int i = 0; i < 13; i++) begin
      check_output($sformatf("seq_ctrl_c%0d", i + 1), ctrl_bits(), tbl[i].ctrl);
      if (tbl[i].chk_num) begin
        check_output($sformatf("seq_round_c%0d", i + 1), round_num, tbl[i].round_num);
        check_output($sformatf("seq_rcon_c%0d", i + 1), rcon, tbl[i].rcon);
      end
      if (state_en) se_count++;
      tick();
    end
    check_output("state_en_count", se_count, 11);

    // Back-to-back starts with START_VALID held high: one accept every 13 cycles.
    start_valid = 1'b1;
    first_init = -1; second_init = -1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (sel_init) begin
        if (first_init < 0) first_init = t;
        else if (second_init < 0) second_init = t;
      end
    end
    start_valid = 1'b0;
    check_output("start_interval", second_init - first_init, 13);
    wait_idle("idle_after_b2b");

    // Result held while DONE_READY is low; starts during DONE are ignored.
    done_ready = 1'b0;
    start_and_time(40, lat);
    check_output("hold_latency", lat, 12);
    start_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("hold_ctrl_%0d", k), ctrl_bits(), 7'b0000110);
      tick();
    end
    done_ready = 1'b1;
    tick();
    check_output("release_idle_ctrl", ctrl_bits(), 7'b0000001);
    tick();
    start_valid = 1'b0;
    check_output("restart_init_ctrl", ctrl_bits(), 7'b1011100);
    wait_idle("idle_after_hold");

    // Synchronous reset in round 4 aborts silently.
    apply_stimulus(1'b1, 1'b1);
    start_valid = 1'b0;
    for (int k = 0; k < 20 && round_num != 4'd4; k++) tick();
    check_output("reached_round4", round_num, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rst_mid_ctrl", ctrl_bits(), 7'b0000001);
    check_output("rst_mid_round_num", round_num, 0);
    check_output("rst_mid_rcon", rcon, 8'h01);
    dv_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done_valid) dv_seen++;
    end
    check_output("no_done_after_rst", dv_seen, 0);

`ifdef AES128_ROUND_CTRL_ABORT_EN
    // Abort in round 6, then an immediate restart with full latency.
    apply_stimulus(1'b1, 1'b1);
    start_valid = 1'b0;
    for (int k = 0; k < 20 && round_num != 4'd6; k++) tick();
    check_output("reached_round6", round_num, 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_ctrl", ctrl_bits(), 7'b0000001);
    check_output("abort_round_num", round_num, 0);
    check_output("abort_rcon", rcon, 8'h01);
    start_and_time(40, lat);
    check_output("abort_restart_latency", lat, 12);
    wait_idle("idle_after_abort");
`endif

    // Three cycles per round: enables only on every third cycle.
    start_valid3 = 1'b1;
    tick();
    start_valid3 = 1'b0;
    se_count = 0;
    for (int c = 1; c <= 33; c++) begin
      logic exp_se, exp_dv, exp_sf;
      exp_se = (c == 1) || (c >= 4 && c <= 31 && ((c - 4) % 3) == 0);
      exp_dv = (c == 32);
      exp_sf = (c >= 29 && c <= 31);
      check_output($sformatf("rc3_c%0d", c), {state_en3, done_valid3, sel_final3},
                   {exp_se, exp_dv, exp_sf});
      if (state_en3) se_count++;
      tick();
    end
    check_output("rc3_state_en_count", se_count, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Sequencing controller for the AES-128 encrypt datapath (state register, key-schedule register, round-input muxes).
- Accepts a start handshake and walks the datapath through the initial AddRoundKey, the middle rounds and the final round.
- Supplies RCON and the mux/enable controls, then presents completion through a valid/ready handshake.
- Sits between the host interface logic and the round datapath.

Parameters:
- NUM_ROUNDS, 10: total rounds after the initial AddRoundKey; legal range 2..14.
- ROUND_CYCLES, 1: clock cycles per round, for multi-cycle round datapaths; legal range 1..4.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START_VALID  input  1  host requests a block encryption.
- START_READY  output  1  controller can accept a start.
- ROUND_NUM  output  4  current round index: 0 = init, 1..NUM_ROUNDS.
- RCON  output  8  round constant for the key schedule in the current round.
- SEL_INIT  output  1  datapath selects plaintext XOR key (initial AddRoundKey).
- SEL_FINAL  output  1  datapath bypasses MixColumns (final round).
- STATE_EN  output  1  state-register load enable.
- KEY_EN  output  1  round-key-register load enable.
- BUSY  output  1  high in any state other than IDLE.
- DONE_VALID  output  1  ciphertext in the state register is valid.
- DONE_READY  input  1  host consumes the result.

Behaviour:
- Reset: RST sampled high at a rising CLK edge forces IDLE and zeroes all outputs except START_READY (1) and RCON (8'h01).
  - Reset mid-operation aborts silently; no DONE_VALID is produced.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - START_READY=1.
  - START_VALID && START_READY -> INIT.
- INIT (exactly 1 cycle):
  - ROUND_NUM=0, SEL_INIT=1, STATE_EN=1, KEY_EN=1.
  - Next state is ROUND, with ROUND_NUM=1 and RCON=8'h01.
- ROUND:
  - Sub-cycle counter runs 0..ROUND_CYCLES-1.
  - STATE_EN and KEY_EN are high only on the last sub-cycle.
  - After the last sub-cycle: ROUND_NUM increments, RCON <= xtime(RCON).
  - When the incremented value equals NUM_ROUNDS -> FINAL.
- FINAL:
  - Same sub-cycle rules as ROUND, with SEL_FINAL=1.
  - After the last sub-cycle -> DONE.
- DONE:
  - DONE_VALID=1; held, with outputs stable, until DONE_READY.
  - DONE_VALID && DONE_READY -> IDLE.
  - START_READY is low in DONE, so a START_VALID in the same cycle is not accepted; it is accepted in IDLE on the following cycle.
- RCON arithmetic: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - Sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
  - RCON holds its value outside ROUND and FINAL, and reloads 8'h01 on entry to INIT.
- Latency: DONE_VALID rises exactly 2 + NUM_ROUNDS*ROUND_CYCLES cycles after the start handshake cycle. With defaults this is 12 cycles.
- Throughput: with DONE_READY tied high, a new start is accepted every 3 + NUM_ROUNDS*ROUND_CYCLES cycles.
- Outputs are registered or decoded from registered state only; no combinational path from START_VALID or DONE_READY to any output.
- START_VALID held high while BUSY is ignored; there is no queueing.

Optional Feature:
- Macro: AES128_ROUND_CTRL_ABORT_EN.
- Defined:
  - Adds input ABORT (1 bit).
  - ABORT high in INIT, ROUND, FINAL or DONE -> next state IDLE, ROUND_NUM=0, RCON=8'h01.
  - No DONE_VALID is produced for an aborted block.
  - ABORT in IDLE has no effect.
  - ABORT and RST together: RST wins (same result).
- Undefined: the ABORT port does not exist, and the FSM has no abort transitions.

Decomposition:
- Package aes128_ctrl_pkg holds:
  - state enum (IDLE, INIT, ROUND, FINAL, DONE);
  - constants RCON_INIT=8'h01 and RCON_POLY=8'h1B;
  - function xtime.
- One sub-module, aes128_rcon_gen: RCON register with load-init and advance enables, reused by the key-expansion block.

Test Plan:
- Defaults; START_VALID pulsed at cycle 0, DONE_READY=1 -> SEL_INIT at cycle 1; ROUND_NUM 1..9 on cycles 2..10; SEL_FINAL with ROUND_NUM=10 at cycle 11; DONE_VALID at cycle 12; STATE_EN high on 11 cycles total.
- RCON trace, defaults -> values 01,02,04,08,10,20,40,80,1B,36 on rounds 1..10, checked on each KEY_EN cycle.
- ROUND_CYCLES=3 -> STATE_EN high only every third cycle in ROUND/FINAL; DONE_VALID at cycle 32.
- DONE_READY held low for 5 cycles -> DONE_VALID and all outputs stable; START_VALID during DONE ignored; the start is accepted the cycle after IDLE is re-entered.
- RST asserted for 1 cycle at round 4 -> next cycle IDLE, START_READY=1, RCON=01, ROUND_NUM=0, no DONE_VALID.
- With AES128_ROUND_CTRL_ABORT_EN: ABORT at round 6 -> IDLE next cycle, no DONE_VALID; an immediate restart completes with full 12-cycle latency.
